// File: rtl/pong_pkg.sv
// Shared pong definitions: screen geometry, paddle FSM states, pixel colour type.
// No logic of its own; no latency or flow control.
// Span helper keeps the pixel hit test identical wherever it is used.
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    typedef logic [2:0] color_t;

    // True when lo <= v < lo+len; 11-bit so pos+size never wraps.
    function automatic logic in_span(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock divider: one-clock tick pulse every DIV clocks, counter 0..DIV-1.
// Latency: tick is high during the last count, so state updates on the wrap edge.
// Backpressure: none, free-running; synchronous active-low reset clears the count.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/paddle_ctrl.sv
// Pong paddle: tick-paced accelerating vertical motion plus pixel renderer; PADDLE_AI_EN adds ball tracking.
// Latency: position moves on tick edges; rgb is registered one clock after row/col.
// Backpressure: none; controls are sampled on each tick, reset has priority over everything.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int     SCREEN_Y    = SCREEN_H,
    parameter int     SIZE_X      = 10,
    parameter int     SIZE_Y      = 100,
    parameter int     START_X     = 5,
    parameter int     TICK_DIV    = 10,
    parameter int     STEP_MAX    = 4,
    parameter int     ACCEL_TICKS = 8,
    parameter color_t COLOR       = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       control_up,
    input  logic       control_down,
`ifdef PADDLE_AI_EN
    input  logic       ai_mode,
    input  logic [9:0] ball_y,
`endif
    input  logic [9:0] row,
    input  logic [9:0] col,
    output color_t     rgb,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [7:0] size_x,
    output logic [7:0] size_y,
    output logic       at_top,
    output logic       at_bottom
);

    localparam logic [10:0] Y_MAX    = 11'(SCREEN_Y - SIZE_Y);
    localparam logic [9:0]  Y_RST    = 10'(SCREEN_Y / 2 - SIZE_Y / 2);
    localparam logic [7:0]  STEP_LIM = 8'(STEP_MAX);
    localparam logic [15:0] ACC_LIM  = 16'(ACCEL_TICKS);

    logic        tick;
    state_t      state;
    state_t      dir;
    logic [7:0]  step;
    logic [15:0] accel_cnt;

    logic        same_dir;
    logic [7:0]  eff_step;
    logic [15:0] run_len;
    logic [10:0] sub_y;
    logic [10:0] add_y;
    logic [9:0]  pos_nxt;
    logic [7:0]  step_nxt;
    logic [15:0] accel_nxt;
    logic        hit;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

`ifdef PADDLE_AI_EN
    logic [10:0] centre;
    assign centre = {1'b0, pos_y} + 11'(SIZE_Y / 2);
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else if (tick) begin
            state <= dir;
        end
    end

    always_comb begin
        dir = IDLE;
`ifdef PADDLE_AI_EN
        if (ai_mode) begin
            if ({1'b0, ball_y} + 11'd2 < centre) begin
                dir = UP;
            end else if ({1'b0, ball_y} > centre + 11'd2) begin
                dir = DOWN;
            end
        end else
`endif
        if (control_up && !control_down) begin
            dir = UP;
        end else if (control_down && !control_up) begin
            dir = DOWN;
        end
    end

    // A new or changed direction restarts at step 1; the acceleration run counts this tick.
    always_comb begin
        same_dir  = (dir == state);
        eff_step  = same_dir ? step : 8'd1;
        run_len   = same_dir ? accel_cnt + 16'd1 : 16'd1;
        sub_y     = {1'b0, pos_y} - 11'(eff_step);
        add_y     = {1'b0, pos_y} + 11'(eff_step);
        pos_nxt   = pos_y;
        step_nxt  = 8'd1;
        accel_nxt = 16'd0;
        case (dir)
            UP:      pos_nxt = (11'(eff_step) > {1'b0, pos_y}) ? 10'd0 : sub_y[9:0];
            DOWN:    pos_nxt = (add_y > Y_MAX) ? Y_MAX[9:0] : add_y[9:0];
            default: pos_nxt = pos_y;
        endcase
        if (dir != IDLE) begin
            if (run_len >= ACC_LIM) begin
                step_nxt  = (eff_step >= STEP_LIM) ? STEP_LIM : eff_step + 8'd1;
                accel_nxt = 16'd0;
            end else begin
                step_nxt  = eff_step;
                accel_nxt = run_len;
            end
            // Pinned against a limit: keep pushing state but drop back to the slowest step.
            if ((dir == UP && pos_nxt == 10'd0) ||
                (dir == DOWN && {1'b0, pos_nxt} == Y_MAX)) begin
                step_nxt  = 8'd1;
                accel_nxt = 16'd0;
            end
        end
        hit       = in_span({1'b0, col}, 11'(START_X), 11'(SIZE_X)) &&
                    in_span({1'b0, row}, {1'b0, pos_y}, 11'(SIZE_Y));
        at_top    = (pos_y == 10'd0);
        at_bottom = ({1'b0, pos_y} == Y_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pos_y     <= Y_RST;
            step      <= 8'd1;
            accel_cnt <= 16'd0;
            rgb       <= '0;
        end else begin
            if (tick) begin
                pos_y     <= pos_nxt;
                step      <= step_nxt;
                accel_cnt <= accel_nxt;
            end
            rgb <= hit ? COLOR : 3'b000;
        end
    end

    assign pos_x  = 10'(START_X);
    assign size_x = 8'(SIZE_X);
    assign size_y = 8'(SIZE_Y);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed motion/render scenarios then random controls, reset and pixel probes.
// Reference model tracks position from tick count, run length and clamping arithmetic.
module tb_paddle_ctrl;
    import pong_pkg::*;

    localparam int TDIV  = 10;
    localparam int SMAX  = 4;
    localparam int ACC   = 8;
    localparam int SY    = 480;
    localparam int SZX   = 10;
    localparam int SZY   = 100;
    localparam int SX    = 5;
    localparam int Y_MAX = SY - SZY;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       control_up = 1'b0;
    logic       control_down = 1'b0;
    logic       ai_mode = 1'b0;
    logic [9:0] ball_y = '0;
    logic [9:0] row = '0;
    logic [9:0] col = '0;
    color_t     rgb;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [7:0] size_x;
    logic [7:0] size_y;
    logic       at_top;
    logic       at_bottom;

    int checks = 0;
    int failures = 0;
    int m_pos, m_rgb, m_clocks, m_run, m_dir;

    paddle_ctrl #(
        .SCREEN_Y(SY), .SIZE_X(SZX), .SIZE_Y(SZY), .START_X(SX),
        .TICK_DIV(TDIV), .STEP_MAX(SMAX), .ACCEL_TICKS(ACC), .COLOR(3'b111)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .control_up   (control_up),
        .control_down (control_down),
`ifdef PADDLE_AI_EN
        .ai_mode      (ai_mode),
        .ball_y       (ball_y),
`endif
        .row          (row),
        .col          (col),
        .rgb          (rgb),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .size_x       (size_x),
        .size_y       (size_y),
        .at_top       (at_top),
        .at_bottom    (at_bottom)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behaviour at one clock edge given the inputs that were stable at that edge.
    task automatic model_edge(input logic rst, input logic up, input logic dn, input logic ai,
                              input int r, input int c, input int by);
        int d, stp, tgt;
        if (!rst) begin
            m_pos = SY / 2 - SZY / 2;
            m_rgb = 0; m_clocks = 0; m_run = 0; m_dir = 0;
            return;
        end
        m_rgb = (c >= SX && c < SX + SZX && r >= m_pos && r < m_pos + SZY) ? 7 : 0;
        m_clocks++;
        if (m_clocks % TDIV != 0) return;
        d = 0;
        if (ai) begin
            if (by < m_pos + SZY / 2 - 2) d = -1;
            else if (by > m_pos + SZY / 2 + 2) d = 1;
        end else if (up && !dn) d = -1;
        else if (dn && !up) d = 1;
        if (d == 0) begin
            m_run = 0; m_dir = 0;
            return;
        end
        m_run = (d == m_dir) ? m_run + 1 : 1;
        m_dir = d;
        stp = 1 + (m_run - 1) / ACC;
        if (stp > SMAX) stp = SMAX;
        tgt = m_pos + d * stp;
        if (tgt <= 0) begin tgt = 0; m_run = 0; end
        if (tgt >= Y_MAX) begin tgt = Y_MAX; m_run = 0; end
        m_pos = tgt;
    endtask

    task automatic cycle();
        logic rs, u, dd, a;
        int r, c, b;
        rs = reset; u = control_up; dd = control_down; a = ai_mode;
        r = int'(row); c = int'(col); b = int'(ball_y);
        @(posedge clock);
        model_edge(rs, u, dd, a, r, c, b);
        #1;
        chk_eq("pos_y", pos_y, m_pos);
        chk_eq("rgb", rgb, m_rgb);
        chk_eq("at_top", at_top, m_pos == 0);
        chk_eq("at_bottom", at_bottom, m_pos == Y_MAX);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int hold;
        // Reset state
        run(2);
        chk_eq("rst_pos_y", pos_y, 190);
        chk_eq("rst_rgb", rgb, 0);
        chk_eq("rst_at_top", at_top, 0);
        chk_eq("rst_at_bottom", at_bottom, 0);
        chk_eq("pos_x", pos_x, SX);
        chk_eq("size_x", size_x, SZX);
        chk_eq("size_y", size_y, SZY);
        reset = 1'b1;

        // Acceleration upward, then clamp at the top from pos 2 with step 4
        control_up = 1'b1;
        run(100);
        chk_eq("up10_pos", pos_y, 178);
        run(490);
        chk_eq("up59_pos", pos_y, 2);
        run(10);
        chk_eq("top_pos", pos_y, 0);
        chk_eq("top_flag", at_top, 1);
        run(100);
        chk_eq("top_hold", pos_y, 0);

        // Reverse, then both pressed holds position
        control_up = 1'b0; control_down = 1'b1;
        run(300);
        chk_eq("down30_pos", pos_y, 72);
        control_up = 1'b1;
        run(50);
        chk_eq("both_hold", pos_y, 72);
        control_up = 1'b0;
        run(1000);
        chk_eq("bottom_pos", pos_y, Y_MAX);
        chk_eq("bottom_flag", at_bottom, 1);

        // Pixel rendering around the reset position
        control_down = 1'b0; reset = 1'b0;
        run(2);
        reset = 1'b1;
        row = 10'd190; col = 10'd5;  cycle(); chk_eq("pix_in", rgb, 7);
        row = 10'd290; col = 10'd5;  cycle(); chk_eq("pix_below", rgb, 0);
        row = 10'd190; col = 10'd15; cycle(); chk_eq("pix_right", rgb, 0);
        row = 10'd289; col = 10'd14; cycle(); chk_eq("pix_corner", rgb, 7);
        row = 10'd189; col = 10'd5;  cycle(); chk_eq("pix_above", rgb, 0);

        // Random controls, pixel probes and mid-move resets
        hold = 0;
        for (int i = 0; i < 5000; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(5, 120);
                control_up   = 1'($urandom_range(0, 1));
                control_down = 1'($urandom_range(0, 1));
            end
            hold--;
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                row = 10'(m_pos + $urandom_range(0, 104) - 2);
                col = 10'($urandom_range(0, 20));
            end else begin
                row = 10'($urandom_range(0, 1023));
                col = 10'($urandom_range(0, 1023));
            end
            cycle();
        end

`ifdef PADDLE_AI_EN
        // Ball tracking ignores the manual controls
        reset = 1'b0; control_up = 1'b0; control_down = 1'b0;
        run(2);
        reset = 1'b1; ai_mode = 1'b1; ball_y = 10'd400; control_up = 1'b1;
        run(800);
        chk_eq("ai_pos", pos_y, 350);
        ai_mode = 1'b0; control_up = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_Y, 480, visible rows.
REQ-002 SHALL have parameter SIZE_X, 10, paddle width in pixels.
REQ-003 SHALL have parameter SIZE_Y, 100, paddle height in pixels.
REQ-004 SHALL have parameter START_X, 5, fixed left column.
REQ-005 SHALL have parameter TICK_DIV, 10, clocks per movement tick; range 1..65535.
REQ-006 SHALL have parameter STEP_MAX, 4, maximum pixels moved per tick.
REQ-007 SHALL have parameter ACCEL_TICKS, 8, consecutive same-direction ticks before step increments.
REQ-008 SHALL have parameter COLOR, 3'b111, paddle colour.
REQ-009 SHALL have ports: clock in 1, sole clock; reset in 1, synchronous, active-low.
REQ-010 SHALL have ports: control_up in 1, move toward row 0; control_down in 1, move toward row SCREEN_Y-1.
REQ-011 SHALL have ports: row in 10 and col in 10, pixel being queried.
REQ-012 SHALL have ports: rgb out 3, registered pixel colour; pos_x out 10; pos_y out 10, top row.
REQ-013 SHALL have ports: size_x out 8; size_y out 8; at_top out 1; at_bottom out 1.

Function
REQ-014 SHALL run a tick counter 0..TICK_DIV-1; a tick occurs on the clock where the counter wraps to 0.
REQ-015 SHALL use FSM states IDLE, UP, DOWN, sampled at each tick: only control_up -> UP; only control_down -> DOWN; neither or both -> IDLE.
REQ-016 SHALL on each tick in UP set pos_y = max(0, pos_y - step), and in DOWN set pos_y = min(SCREEN_Y-SIZE_Y, pos_y + step), computed at 11-bit width without wrap.
REQ-017 SHALL keep step at 1 in IDLE, on direction change, and on entry to a state; after ACCEL_TICKS consecutive ticks in one direction, step SHALL increment by 1, saturating at STEP_MAX.
REQ-018 SHALL drive at_top = (pos_y == 0) and at_bottom = (pos_y == SCREEN_Y-SIZE_Y); these are combinational from pos_y.
REQ-019 SHALL hold state and reset step to 1 when clamped at a limit while still pushing into it.
REQ-020 SHALL register rgb one clock after row/col: COLOR when START_X <= col < START_X+SIZE_X and pos_y <= row < pos_y+SIZE_Y, else 3'b000.
REQ-021 SHALL hold pos_x = START_X, size_x = SIZE_X, size_y = SIZE_Y constant.

Reset
REQ-022 SHALL, on a clock edge with reset low, set pos_y = SCREEN_Y/2 - SIZE_Y/2, FSM = IDLE, step = 1, tick counter = 0, accel counter = 0, rgb = 0.
REQ-023 SHALL apply reset mid-move with priority over all other inputs; movement resumes with the first tick TICK_DIV clocks after reset is released.

Configuration
REQ-024 SHALL, with PADDLE_AI_EN defined, add inputs ai_mode in 1 and ball_y in 10; when ai_mode=1, the FSM SHALL ignore controls and select UP if ball_y < paddle centre-2, DOWN if > centre+2, else IDLE.
REQ-025 SHALL, without PADDLE_AI_EN, omit these ports and all related logic.

Structure
REQ-026 SHALL take state enum (IDLE/UP/DOWN), the 3-bit colour type and screen-size constants from shared package pong_pkg.
REQ-027 SHALL instantiate a sub-module tick_gen (parametrised divider emitting a one-clock tick pulse) for REQ-014.

Verification
REQ-028 Reset low for 2 clocks -> pos_y=190, rgb=0, at_top=0, at_bottom=0.
REQ-029 control_up held 10 ticks (100 clocks) from 190 -> ticks 1-8 move 1 each, ticks 9-10 move 2 each; pos_y=178.
REQ-030 pos_y=2, control_up held with step 4 -> pos_y=0, at_top=1, step back to 1; further ticks keep pos_y=0.
REQ-031 control_up and control_down both high for 5 ticks -> pos_y unchanged, FSM IDLE.
REQ-032 row=190, col=5 -> rgb=3'b111 next clock; row=290, col=5 -> rgb=0; col=15 -> rgb=0.
REQ-033 PADDLE_AI_EN, ai_mode=1, ball_y=400, pos_y=190 -> pos_y increases each tick until centre is within 2 of 400, then holds at pos_y=350.
